// File: rtl/cond_flag_unit.sv
// Condition-flag register with bypassed condition evaluation and a
// 2-entry in-order response queue plus query/taken statistics.
module cond_flag_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    input  logic [2:0]  alu_op,
    input  logic        flag_we,
    input  logic        req_valid,
    input  logic [3:0]  req_cond,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic        rsp_taken,
    output logic        rsp_err,
    input  logic        rsp_ready,
    output logic [3:0]  flags,
    output logic [15:0] taken_cnt,
    output logic [15:0] query_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] flags_byp;
    logic       push;
    logic       pop;
    logic       cond_taken;
    logic       cond_err;
    logic [1:0] mem_taken;
    logic [1:0] mem_err;
    logic       wr_ptr;
    logic       rd_ptr;

    function automatic logic eval_cond(input logic [3:0] cond,
                                       input logic [3:0] f);
        logic n, z, c, v, r;
        {n, z, c, v} = f;
        r = 1'b0;
        unique case (cond)
            4'd0:  r = z;
            4'd1:  r = !z;
            4'd2:  r = c;
            4'd3:  r = !c;
            4'd4:  r = n;
            4'd5:  r = !n;
            4'd6:  r = v;
            4'd7:  r = !v;
            4'd8:  r = c & !z;
            4'd9:  r = !c | z;
            4'd10: r = (n == v);
            4'd11: r = (n != v);
            4'd12: r = !z & (n == v);
            4'd13: r = z | (n != v);
            4'd14: r = 1'b1;
            4'd15: r = 1'b0;
        endcase
        return r;
    endfunction

    // Flags as they will be after this edge; queries see this value.
    always_comb begin
        flags_byp = flags;
        if (flag_we) begin
            unique case (alu_op)
                3'd1, 3'd2:             flags_byp = {alu_n, alu_z, alu_c, alu_v};
                3'd3, 3'd4, 3'd5, 3'd6: flags_byp = {alu_n, alu_z, flags[1:0]};
                default:                flags_byp = flags;
            endcase
        end
    end

    assign cond_taken = eval_cond(req_cond, flags_byp);
    assign cond_err   = (req_cond == 4'd15);

    assign req_ready = rst & (state != FULL);
    assign rsp_valid = (state != EMPTY);
    assign push      = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_taken = rsp_valid & mem_taken[rd_ptr];
    assign rsp_err   = rsp_valid & mem_err[rd_ptr];

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL:    if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            flags     <= 4'b0000;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            mem_taken <= 2'b00;
            mem_err   <= 2'b00;
            taken_cnt <= 16'd0;
            query_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            flags <= flags_byp;
            if (push) begin
                mem_taken[wr_ptr] <= cond_taken;
                mem_err[wr_ptr]   <= cond_err;
                wr_ptr            <= ~wr_ptr;
                query_cnt         <= query_cnt + 16'd1;
                if (cond_taken && taken_cnt != 16'hFFFF)
                    taken_cnt <= taken_cnt + 16'd1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit with a queue-based reference model
// compared on every falling edge, plus literal spot checks.
module tb_cond_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic [2:0]  alu_op;
    logic        flag_we;
    logic        req_valid;
    logic [3:0]  req_cond;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_taken;
    logic        rsp_err;
    logic        rsp_ready;
    logic [3:0]  flags;
    logic [15:0] taken_cnt;
    logic [15:0] query_cnt;

    int tests = 0;
    int fails = 0;

    cond_flag_unit dut (
        .clk(clk), .rst(rst),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .alu_op(alu_op), .flag_we(flag_we),
        .req_valid(req_valid), .req_cond(req_cond), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_taken(rsp_taken), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .flags(flags),
        .taken_cnt(taken_cnt), .query_cnt(query_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: flags as named bits, responses as a bounded queue.
    bit       m_n, m_z, m_c, m_v;
    bit [1:0] m_q[$];
    int       m_taken;
    int       m_query;
    bit       started = 0;

    function automatic bit cond_true(input int code, input bit n, input bit z,
                                     input bit c, input bit v);
        bit ge;
        ge = (n == v);
        case (code)
            0: return z;
            1: return !z;
            2: return c;
            3: return !c;
            4: return n;
            5: return !n;
            6: return v;
            7: return !v;
            8: return c && !z;
            9: return !(c && !z);
            10: return ge;
            11: return !ge;
            12: return !z && ge;
            13: return !(!z && ge);
            14: return 1;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit acc, pp, t, e;
        if (rst === 1'b0) begin
            started = 1;
            {m_n, m_z, m_c, m_v} = 4'b0000;
            m_q.delete();
            m_taken = 0;
            m_query = 0;
        end else if (started) begin
            if (flag_we && (alu_op == 1 || alu_op == 2)) begin
                m_n = alu_n; m_z = alu_z; m_c = alu_c; m_v = alu_v;
            end else if (flag_we && alu_op >= 3 && alu_op <= 6) begin
                m_n = alu_n; m_z = alu_z;
            end
            acc = req_valid && (m_q.size() < 2);
            pp  = rsp_ready && (m_q.size() > 0);
            if (pp) void'(m_q.pop_front());
            if (acc) begin
                t = cond_true(int'(req_cond), m_n, m_z, m_c, m_v);
                e = (req_cond == 4'd15);
                m_q.push_back({t, e});
                m_query = (m_query + 1) % 65536;
                if (t && m_taken < 65535) m_taken++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_flags", 32'(flags), 32'({m_n, m_z, m_c, m_v}));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_q.size() > 0));
            chk("m_req_ready", 32'(req_ready), 32'(rst && m_q.size() < 2));
            chk("m_taken_cnt", 32'(taken_cnt), 32'(m_taken));
            chk("m_query_cnt", 32'(query_cnt), 32'(m_query));
            if (m_q.size() > 0) begin
                chk("m_rsp_taken", 32'(rsp_taken), 32'(m_q[0][1]));
                chk("m_rsp_err", 32'(rsp_err), 32'(m_q[0][0]));
            end else begin
                chk("m_rsp_idle", 32'({rsp_taken, rsp_err}), 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit we, input int op, input bit [3:0] nzcv);
        flag_we = we;
        alu_op  = 3'(op);
        {alu_n, alu_z, alu_c, alu_v} = nzcv;
    endtask

    task automatic rq(input bit vld, input int code);
        req_valid = vld;
        req_cond  = 4'(code);
    endtask

    initial begin
        rst = 1'b0;
        wr(0, 0, 4'b0000);
        rq(0, 0);
        rsp_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cnts", {taken_cnt, query_cnt}, 32'd0);
        rst = 1'b1;
        cyc();
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        // flag write rules
        wr(1, 2, 4'b0100); cyc();
        chk("fw_sub", 32'(flags), 32'h4);
        wr(1, 4, 4'b1000); cyc();
        chk("fw_or", 32'(flags), 32'h8);
        wr(1, 7, 4'b0111); cyc();
        chk("fw_const", 32'(flags), 32'h8);
        wr(1, 5, 4'b0011); cyc();
        chk("fw_xor", 32'(flags), 32'h0);

        // bypass: write Z and query EQ on the same edge
        wr(1, 1, 4'b0100); rq(1, 0); cyc();
        wr(0, 0, 4'b0000); rq(0, 0);
        chk("byp_valid", 32'(rsp_valid), 32'd1);
        chk("byp_taken", 32'(rsp_taken), 32'd1);
        chk("byp_cnts", {taken_cnt, query_cnt}, {16'd1, 16'd1});
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;

        // backpressure with N=1, V=1
        wr(1, 1, 4'b1001); cyc(); wr(0, 0, 4'b0000);
        rq(1, 10); cyc();
        rq(1, 11); cyc();
        chk("bp_full", 32'(req_ready), 32'd0);
        rq(1, 14); cyc();
        chk("bp_hold", 32'(query_cnt), 32'd3);
        chk("bp_head_ge", 32'(rsp_taken), 32'd1);
        rsp_ready = 1'b1; cyc();
        chk("bp_head_lt", 32'(rsp_taken), 32'd0);
        chk("bp_ready", 32'(req_ready), 32'd1);
        cyc();
        rq(0, 0);
        chk("pp_valid", 32'(rsp_valid), 32'd1);
        chk("pp_head_al", 32'(rsp_taken), 32'd1);
        cyc();
        chk("bp_drained", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // reserved code
        rq(1, 15); cyc(); rq(0, 0);
        chk("rsv_err", {rsp_taken, rsp_err}, 32'b01);
        chk("rsv_cnts", {taken_cnt, query_cnt}, {16'd3, 16'd5});
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;

        // mixed pattern sweep, checked by the model
        for (int i = 0; i < 48; i++) begin
            wr(i % 3 != 0, i % 8, 4'(i * 7));
            rq(i % 5 != 4, i % 16);
            rsp_ready = (i % 4 != 0);
            cyc();
        end
        wr(0, 0, 4'b0000); rq(0, 0); rsp_ready = 1'b0;
        cyc();

        // reset while full with flags set
        wr(1, 1, 4'b1111); rq(1, 14); cyc(); cyc();
        wr(0, 0, 4'b0000); rq(0, 0);
        chk("mr_flags", 32'(flags), 32'hF);
        chk("mr_full", 32'(req_ready), 32'd0);
        rst = 1'b0;
        wr(1, 1, 4'b1010); rq(1, 14); cyc();
        wr(0, 0, 4'b0000); rq(0, 0);
        chk("mr_valid", 32'(rsp_valid), 32'd0);
        chk("mr_flags0", 32'(flags), 32'd0);
        chk("mr_cnts", {taken_cnt, query_cnt}, 32'd0);
        rst = 1'b1; cyc();
        chk("mr_ready", 32'(req_ready), 32'd1);

        // counter saturation and wrap
        rsp_ready = 1'b1;
        rq(1, 14);
        repeat (65535) cyc();
        chk("sat_taken", 32'(taken_cnt), 32'hFFFF);
        chk("sat_query", 32'(query_cnt), 32'hFFFF);
        cyc();
        rq(0, 0);
        chk("wrap_query", 32'(query_cnt), 32'h0);
        chk("wrap_taken", 32'(taken_cnt), 32'hFFFF);
        cyc();
        rsp_ready = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
